// File: rtl/key_debounce_pkg.sv
// Shared lab-wide debounce types and constants.
// State encoding is fixed so later labs can decode it directly.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_HI = 2'b00,
        WAIT_LO = 2'b01,
        IDLE_LO = 2'b10,
        WAIT_HI = 2'b11
    } db_state_e;

    // 10 ms of stable samples at 50 MHz
    localparam int DEBOUNCE_50MHZ = 500000;
    localparam int DEBOUNCE_CNT_W = 20;

    function automatic logic is_wait(input db_state_e s);
        return (s == WAIT_LO) || (s == WAIT_HI);
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Button-side bundle: raw key in, conditioned level and strobes out.
interface key_debounce_if;
    import key_debounce_pkg::*;

    logic key_n;
    logic key_clean;
    logic press;
    logic release_p;
    logic bouncing;

    modport master (
        output key_n,
        input  key_clean,
        input  press,
        input  release_p,
        input  bouncing
    );

    modport slave (
        input  key_n,
        output key_clean,
        output press,
        output release_p,
        output bouncing
    );

endinterface

// File: rtl/key_debounce_sync_chain.sv
// Multi-flop synchroniser for one asynchronous input bit.
// Resets to RST_VAL so an idle active-low input reads as released.
module sync_chain
    import key_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], d_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// Pushbutton debouncer: synchronise, qualify a stable level,
// emit a clean active-low level plus press/release strobes.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = DEBOUNCE_50MHZ,
    parameter int CNT_W         = DEBOUNCE_CNT_W
) (
    input  logic         clock,
    input  logic         resetn,
    key_debounce_if.slave key
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic      s;
    db_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic      clean_q, clean_d;
    logic      press_q, press_d;
    logic      rel_q, rel_d;
    logic      bounce_q, bounce_d;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_sync (
        .clk_i  (clock),
        .rst_ni (resetn),
        .d_i    (key.key_n),
        .q_o    (s)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE_HI;
            cnt_q    <= '0;
            clean_q  <= 1'b1;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            bounce_q <= bounce_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            IDLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                    press_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            IDLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_HI;
                cnt_d   = '0;
                clean_d = 1'b1;
            end
        endcase
        bounce_d = is_wait(state_d);
    end

    assign key.key_clean = clean_q;
    assign key.press     = press_q;
    assign key.release_p = rel_q;
    assign key.bouncing  = bounce_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with a short qualification window.
// Expected outputs come from a sliding run-length reference.
module tb_key_debounce;
    import key_debounce_pkg::*;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;

    typedef struct packed {
        logic clean;
        logic press;
        logic rel;
        logic bnc;
    } exp_t;

    logic clock;
    logic resetn;
    key_debounce_if kif ();

    key_debounce #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .CNT_W         (3)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .key    (kif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    // reference: raw-key delay line plus run length of the sample
    logic p1, p2, last_s, m_clean;
    int   run;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        p1 = 1'b1; p2 = 1'b1; last_s = 1'b1;
        m_clean = 1'b1; run = 0;
    endtask

    function automatic exp_t model_edge(input logic kn);
        exp_t e;
        logic s;
        logic acc;
        s  = p2;
        p2 = p1;
        p1 = kn;
        if (s == last_s) run = (run < 1000) ? run + 1 : run;
        else run = 1;
        last_s = s;
        acc = (s != m_clean) && (run >= STABLE);
        e.press = acc && !s;
        e.rel   = acc && s;
        if (acc) m_clean = s;
        e.clean = m_clean;
        e.bnc   = (s != m_clean);
        return e;
    endfunction

    task automatic step(input logic kn, output logic pr, output logic rl);
        exp_t e;
        @(negedge clock);
        kif.key_n = kn;
        sb_q.push_back(model_edge(kn));
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        check("key_clean", 8'(kif.key_clean), 8'(e.clean));
        check("press",     8'(kif.press),     8'(e.press));
        check("release_p", 8'(kif.release_p), 8'(e.rel));
        check("bouncing",  8'(kif.bouncing),  8'(e.bnc));
        pr = kif.press;
        rl = kif.release_p;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_clean"}, 8'(kif.key_clean), 8'd1);
        check({tag, "_press"}, 8'(kif.press),     8'd0);
        check({tag, "_rel"},   8'(kif.release_p), 8'd0);
        check({tag, "_bnc"},   8'(kif.bouncing),  8'd0);
    endtask

    // drive kn for n edges; report edge index of first press/release
    task automatic hold(input logic kn, input int n,
                        output int p_at, output int r_at);
        logic pr, rl;
        p_at = -1;
        r_at = -1;
        for (int i = 0; i < n; i++) begin
            step(kn, pr, rl);
            if (pr && p_at < 0) p_at = i;
            if (rl && r_at < 0) r_at = i;
        end
    endtask

    initial begin
        int pa, ra, pa2, ra2;
        logic pr, rl;
        resetn    = 1'b0;
        kif.key_n = 1'b1;
        model_reset();

        // reset held while the key chatters
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            kif.key_n = i[0];
            @(posedge clock);
            #1;
            check_reset_vals("rst_hold");
        end
        @(negedge clock);
        kif.key_n = 1'b1;
        resetn    = 1'b1;
        hold(1'b1, 4, pa, ra);
        check("idle_no_press", 8'(pa + 1), 8'd0);

        // clean press: strobe on edge 5 counted from the change
        hold(1'b0, 8, pa, ra);
        check("press_latency", 8'(pa), 8'(SYNC + STABLE - 1));
        check("press_clean", 8'(kif.key_clean), 8'd0);

        // clean release
        hold(1'b1, 8, pa, ra);
        check("rel_latency", 8'(ra), 8'(SYNC + STABLE - 1));
        check("rel_no_press", 8'(pa + 1), 8'd0);

        // short bounce is rejected
        hold(1'b0, 3, pa, ra);
        hold(1'b1, 1, pa2, ra2);
        check("rej_a", 8'(pa + pa2 + 2), 8'd0);
        hold(1'b0, 2, pa, ra);
        hold(1'b1, 8, pa2, ra2);
        check("rej_b", 8'(pa + pa2 + 2), 8'd0);
        check("rej_clean", 8'(kif.key_clean), 8'd1);

        // bounce then settle: press 6 edges after the final fall
        hold(1'b0, 2, pa, ra);
        hold(1'b1, 1, pa2, ra2);
        check("settle_early", 8'(pa + pa2 + 2), 8'd0);
        hold(1'b0, 10, pa, ra);
        check("settle_latency", 8'(pa), 8'(SYNC + STABLE - 1));
        hold(1'b1, 8, pa, ra);
        check("settle_rel", 8'(ra), 8'(SYNC + STABLE - 1));

        // reset lands in WAIT_LO with count 2
        hold(1'b0, 4, pa, ra);
        check("midq_bnc", 8'(kif.bouncing), 8'd1);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check_reset_vals("rst_async");
        model_reset();
        @(posedge clock);
        #1;
        check_reset_vals("rst_midq");
        @(negedge clock);
        kif.key_n = 1'b1;
        resetn    = 1'b1;
        hold(1'b1, 8, pa, ra);
        check("post_rst_press", 8'(pa + 1), 8'd0);
        check("post_rst_rel",   8'(ra + 1), 8'd0);

        step(1'b1, pr, rl);
        check("sb_empty", 8'(sb_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
